// File: rtl/spi_pkg.sv
// Shared register offsets, CTRL/STATUS bit positions and FSM encoding for the SPI master.
package spi_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_TXDATA = 2'd2;
    localparam logic [1:0] REG_RXDATA = 2'd3;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_DIV_LSB = 1;
    localparam int CTRL_CS_BIT  = 8;
    localparam int CTRL_LB_BIT  = 9;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_RXV_BIT  = 1;

    localparam int CLK_DIV_MIN = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0, MSB-first single-byte shifter: SCK divider, MOSI shift-out and MISO sample-in.
// state    | meaning
// ST_IDLE  | SCK low, waiting for start
// ST_SHIFT | byte in flight, SCK toggles every clk_div cycles
module spi_shift_engine #(
    parameter int CLK_DIV_W = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [7:0]           tx_byte,
    input  logic [CLK_DIV_W-1:0] clk_div,
    input  logic                 miso,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           rx_byte,
    output logic                 sck,
    output logic                 mosi
);
    import spi_pkg::*;

    spi_state_e           state_q, state_d;
    logic [CLK_DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic                 sck_q, sck_d;
    logic [7:0]           tx_sh_q, tx_sh_d;
    logic [7:0]           rx_sh_q, rx_sh_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            sck_q     <= 1'b0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        sck_d     = sck_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        bit_cnt_d = bit_cnt_q;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d   = ST_SHIFT;
                    tx_sh_d   = tx_byte;
                    div_cnt_d = clk_div - 1'b1;
                    sck_d     = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    sck_d   = 1'b0;
                end else if (div_cnt_q == '0) begin
                    div_cnt_d = clk_div - 1'b1;
                    sck_d     = ~sck_q;
                    if (!sck_q) begin
                        rx_sh_d = {rx_sh_q[6:0], miso};
                    end else begin
                        // falling edge: advance MOSI; the 8th one ends the byte
                        tx_sh_d   = {tx_sh_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_IDLE;
                            done    = 1'b1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy    = (state_q == ST_SHIFT);
    assign mosi    = busy & tx_sh_q[7];
    assign sck     = sck_q;
    assign rx_byte = rx_sh_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// Register-mapped single-byte SPI master (mode 0): reg file, clk_div clamp and chip-select logic.
// Optional macro SPI_LOOPBACK_EN adds CTRL bit9 to feed MOSI back into the receiver.
module spi_master_ctrl #(
    parameter int CLK_DIV_W   = 7,
    parameter int CLK_DIV_MIN = spi_pkg::CLK_DIV_MIN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic [31:0] rdata,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    import spi_pkg::*;

    logic                 en_q, en_d;
    logic [CLK_DIV_W-1:0] div_q, div_d;
    logic                 cs_q, cs_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [7:0]           rxdata_q, rxdata_d;
    logic                 lb_q;

    logic [1:0] addr;
    logic       wr_en, ctrl_wr, tx_wr, rx_rd;
    logic       start, abort, busy, done, miso_sel;
    logic [7:0] rx_byte;
    logic       unused_bits;

    assign addr    = req_addr[3:2];
    assign wr_en   = req_valid & req_write & req_wstrb[0];
    assign ctrl_wr = wr_en && (addr == REG_CTRL);
    assign tx_wr   = wr_en && (addr == REG_TXDATA);
    assign rx_rd   = req_valid && !req_write && (addr == REG_RXDATA);
    assign start   = tx_wr && en_q && !busy;
    // abort on the same edge that clears spi_en so SCK drops with the write
    assign abort   = !en_d;

`ifdef SPI_LOOPBACK_EN
    logic lb_d;
    always_comb begin
        lb_d = lb_q;
        if (ctrl_wr && req_wstrb[1]) lb_d = req_wdata[CTRL_LB_BIT];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lb_q <= 1'b0;
        else        lb_q <= lb_d;
    end
    assign miso_sel    = lb_q ? spi_mosi : spi_miso;
    assign unused_bits = ^{req_addr[31:4], req_addr[1:0], req_wdata[31:10], req_wstrb[3:2]};
`else
    assign lb_q        = 1'b0;
    assign miso_sel    = spi_miso;
    assign unused_bits = ^{req_addr[31:4], req_addr[1:0], req_wdata[31:9], req_wstrb[3:2], lb_q};
`endif

    always_comb begin
        en_d       = en_q;
        div_d      = div_q;
        cs_d       = cs_q;
        rx_valid_d = rx_valid_q;
        rxdata_d   = rxdata_q;
        if (ctrl_wr) begin
            en_d  = req_wdata[CTRL_EN_BIT];
            div_d = req_wdata[CTRL_DIV_LSB +: CLK_DIV_W];
            if (en_d && (div_d == '0)) div_d = CLK_DIV_W'(CLK_DIV_MIN);
            if (req_wstrb[1]) cs_d = req_wdata[CTRL_CS_BIT];
        end
        // completion outranks a same-cycle RXDATA read
        if (done) begin
            rx_valid_d = 1'b1;
            rxdata_d   = rx_byte;
        end else if (start || rx_rd) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            div_q      <= '0;
            cs_q       <= 1'b0;
            rx_valid_q <= 1'b0;
            rxdata_q   <= '0;
        end else begin
            en_q       <= en_d;
            div_q      <= div_d;
            cs_q       <= cs_d;
            rx_valid_q <= rx_valid_d;
            rxdata_q   <= rxdata_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (req_valid && !req_write) begin
            case (addr)
                REG_CTRL: begin
                    rdata[CTRL_EN_BIT]                  = en_q;
                    rdata[CTRL_DIV_LSB +: CLK_DIV_W]    = div_q;
                    rdata[CTRL_CS_BIT]                  = cs_q;
                    rdata[CTRL_LB_BIT]                  = lb_q;
                end
                REG_STATUS: begin
                    rdata[STAT_BUSY_BIT] = busy;
                    rdata[STAT_RXV_BIT]  = rx_valid_q;
                end
                REG_RXDATA: rdata[7:0] = rxdata_q;
                default:    rdata = '0;
            endcase
        end
    end

    assign spi_cs_n = ~(en_q & cs_q);

    spi_shift_engine #(.CLK_DIV_W(CLK_DIV_W)) u_engine (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .tx_byte (req_wdata[7:0]),
        .clk_div (div_q),
        .miso    (miso_sel),
        .busy    (busy),
        .done    (done),
        .rx_byte (rx_byte),
        .sck     (spi_sck),
        .mosi    (spi_mosi)
    );

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: CTRL vector table, flash-model transfers via a scoreboard, corner sequences.
module tb_spi_master_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic [31:0] rdata;
    logic        spi_cs_n, spi_sck, spi_mosi, spi_miso;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    spi_master_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rdata     (rdata),
        .spi_cs_n  (spi_cs_n),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    // flash model: JEDEC ID 0x9F -> EF 40 16; READ 0x03 + 24-bit addr returns addr[7:0]+n
    logic [7:0]  m_in = '0, m_out = '0, m_cmd = '0, m_next = '0, mon_tx = '0;
    logic [23:0] m_addr = '0;
    int          m_bits = 0, m_idx = 0;

    assign spi_miso = spi_cs_n ? 1'b1 : m_out[7];

    function automatic logic [7:0] flash_next(logic [7:0] cmd, logic [23:0] a, int idx);
        if (cmd == 8'h9F) begin
            case (idx)
                0: return 8'hEF;
                1: return 8'h40;
                2: return 8'h16;
                default: return 8'h00;
            endcase
        end
        if (cmd == 8'h03 && idx >= 3) return a[7:0] + 8'(idx - 3);
        return 8'h00;
    endfunction

    always @(negedge spi_cs_n) begin
        m_bits = 0;
        m_idx  = 0;
        m_out  = 8'h00;
    end

    always @(posedge spi_sck) begin
        mon_tx = {mon_tx[6:0], spi_mosi};
        if (!spi_cs_n) begin
            m_in = {m_in[6:0], spi_mosi};
            m_bits++;
            if (m_bits == 8) begin
                m_bits = 0;
                if (m_idx == 0) m_cmd = m_in;
                else if (m_idx <= 3) m_addr = {m_addr[15:0], m_in};
                m_next = flash_next(m_cmd, m_addr, m_idx);
                m_idx++;
            end
        end
    end

    always @(negedge spi_sck) begin
        if (!spi_cs_n) begin
            if (m_bits == 0) m_out = m_next;
            else             m_out = {m_out[6:0], 1'b0};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'b0; req_wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a;
        #1;
        d = rdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(output logic [31:0] st);
        int n = 0;
        do begin
            bus_read(32'h4, st);
            n++;
        end while (st[0] && n < 400);
        chk("busy_clear", {31'b0, st[0]}, 32'h0);
    endtask

    task automatic xfer(input logic [7:0] tx, input logic [7:0] exp_rx);
        logic [31:0] st, rd;
        exp_q.push_back(exp_rx);
        bus_write(32'h8, {24'b0, tx});
        bus_read(32'h4, st);
        chk("busy_set", {31'b0, st[0]}, 32'h1);
        wait_done(st);
        chk("rx_valid_set", {31'b0, st[1]}, 32'h1);
        bus_read(32'hC, rd);
        chk("rxdata", rd, {24'b0, exp_q.pop_front()});
        bus_read(32'h4, st);
        chk("rx_valid_clr", {31'b0, st[1]}, 32'h0);
    endtask

    typedef struct packed {
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        exp_cs_n;
    } vec_t;

`ifdef SPI_LOOPBACK_EN
    localparam logic [31:0] LB_MASK = 32'h200;
`else
    localparam logic [31:0] LB_MASK = 32'h0;
`endif

    vec_t vecs[9];

    initial begin
        logic [31:0] rd;
        int n;

        vecs[0] = '{32'h5,        32'h5,                      1'b1};
        vecs[1] = '{32'h1,        32'h5,                      1'b1};
        vecs[2] = '{32'h0,        32'h0,                      1'b1};
        vecs[3] = '{32'h2,        32'h2,                      1'b1};
        vecs[4] = '{32'h205,      32'h5 | LB_MASK,            1'b1};
        vecs[5] = '{32'hFFFFFFFF, 32'h1FF | LB_MASK,          1'b0};
        vecs[6] = '{32'h100,      32'h100,                    1'b1};
        vecs[7] = '{32'h101,      32'h105,                    1'b0};
        vecs[8] = '{32'h103,      32'h103,                    1'b0};

        repeat (2) @(negedge clk);
        chk("rst_cs_n", {31'b0, spi_cs_n}, 32'h1);
        chk("rst_sck", {31'b0, spi_sck}, 32'h0);
        chk("rst_mosi", {31'b0, spi_mosi}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        bus_read(32'h0, rd);  chk("rst_ctrl", rd, 32'h0);
        bus_read(32'h4, rd);  chk("rst_status", rd, 32'h0);
        bus_read(32'hC, rd);  chk("rst_rxdata", rd, 32'h0);

        for (int i = 0; i < 9; i++) begin
            bus_write(32'h0, vecs[i].wdata);
            chk($sformatf("vec%0d_cs_n", i), {31'b0, spi_cs_n}, {31'b0, vecs[i].exp_cs_n});
            bus_read(32'h0, rd);
            chk($sformatf("vec%0d_ctrl", i), rd, vecs[i].exp);
        end
        bus_write(32'h8, 32'h77);
        bus_read(32'h8, rd);
        chk("txdata_reads_0", rd, 32'h0);
        wait_done(rd);

        // JEDEC ID
        bus_write(32'h0, 32'h5);
        bus_write(32'h0, 32'h105);
        chk("cs_low", {31'b0, spi_cs_n}, 32'h0);
        xfer(8'h9F, 8'h00);
        xfer(8'h00, 8'hEF);
        xfer(8'h00, 8'h40);
        xfer(8'h00, 8'h16);

        // READ at 0x000010
        bus_write(32'h0, 32'h5);
        chk("cs_high_between", {31'b0, spi_cs_n}, 32'h1);
        bus_write(32'h0, 32'h105);
        xfer(8'h03, 8'h00);
        xfer(8'h00, 8'h00);
        xfer(8'h00, 8'h00);
        xfer(8'h10, 8'h00);
        for (int i = 0; i < 4; i++) xfer(8'h00, 8'h10 + 8'(i));
        bus_write(32'h0, 32'h5);
        chk("cs_release", {31'b0, spi_cs_n}, 32'h1);

        // abort mid-byte: RXDATA keeps 0x13
        bus_write(32'h8, 32'h5A);
        n = 0;
        while (!spi_sck && n < 100) begin @(negedge clk); n++; end
        chk("abort_sck_seen", {31'b0, spi_sck}, 32'h1);
        bus_write(32'h0, 32'h4);
        chk("abort_sck_low", {31'b0, spi_sck}, 32'h0);
        bus_read(32'h4, rd);
        chk("abort_status", rd, 32'h0);
        bus_read(32'hC, rd);
        chk("abort_rxdata", rd, 32'h13);

        // TXDATA write while busy is dropped
        bus_write(32'h0, 32'h5);
        exp_q.push_back(8'hFF);
        bus_write(32'h8, 32'hA5);
        repeat (6) @(negedge clk);
        bus_write(32'h8, 32'h3C);
        bus_read(32'h4, rd);
        chk("busy_mid", {31'b0, rd[0]}, 32'h1);
        wait_done(rd);
        chk("busy_rx_valid", {31'b0, rd[1]}, 32'h1);
        chk("inflight_tx", {24'b0, mon_tx}, 32'hA5);
        bus_read(32'hC, rd);
        chk("inflight_rx", rd, {24'b0, exp_q.pop_front()});
        bus_read(32'h4, rd);
        chk("no_queued_xfer", rd, 32'h0);

`ifdef SPI_LOOPBACK_EN
        bus_write(32'h0, 32'h205);
        xfer(8'hA5, 8'hA5);
`endif

        // TXDATA write with spi_en=0
        bus_write(32'h0, 32'h4);
        bus_write(32'h8, 32'h55);
        bus_read(32'h4, rd);
        chk("disabled_busy", {31'b0, rd[0]}, 32'h0);
        repeat (10) @(negedge clk);
        chk("disabled_sck", {31'b0, spi_sck}, 32'h0);

        // async reset mid-transfer
        bus_write(32'h0, 32'h105);
        bus_write(32'h8, 32'hFF);
        n = 0;
        while (!spi_sck && n < 100) begin @(negedge clk); n++; end
        chk("rst_mid_sck_seen", {31'b0, spi_sck}, 32'h1);
        chk("rst_mid_mosi_seen", {31'b0, spi_mosi}, 32'h1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cs_n", {31'b0, spi_cs_n}, 32'h1);
        chk("arst_sck", {31'b0, spi_sck}, 32'h0);
        chk("arst_mosi", {31'b0, spi_mosi}, 32'h0);
        chk("arst_rdata", rdata, 32'h0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_read(32'h0, rd);  chk("arst_ctrl", rd, 32'h0);
        bus_read(32'h4, rd);  chk("arst_status", rd, 32'h0);
        bus_read(32'hC, rd);  chk("arst_rxdata", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
